// File: rtl/dispatch_source_sched.sv
// dispatch_source_sched: decodes packed instruction words into network steps,
// with a ring of delayed, saturating spike charge slots. Option: DISPATCH_SAT_CNT_EN.
`default_nettype none

module dispatch_source_sched #(
   parameter int NUM_INP      = 8,
   parameter int CHARGE_WIDTH = 8,
   parameter int RUN_WIDTH    = 16,
   parameter int DELAY_DEPTH  = 4,
   parameter int SRC_WIDTH    = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            src_valid,
   output logic                            src_ready,
   input  logic [SRC_WIDTH-1:0]            src,
   output logic                            out_ready,
   input  logic                            net_ready,
   output logic                            net_valid,
   output logic                            net_clr,
   output logic [NUM_INP*CHARGE_WIDTH-1:0] net_inp
`ifdef DISPATCH_SAT_CNT_EN
   ,
   output logic [15:0]                     sat_count
`endif
);

   localparam int IW  = (NUM_INP > 1) ? $clog2(NUM_INP) : 0;
   localparam int DW  = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 0;
   localparam int IWS = (IW > 0) ? IW : 1;
   localparam int DWS = (DW > 0) ? DW : 1;
   localparam int VAL_MSB = SRC_WIDTH - 4 - IW - DW;

   localparam logic [2:0] OP_RUN = 3'd1;
   localparam logic [2:0] OP_SPK = 3'd2;
   localparam logic [2:0] OP_CLR = 3'd3;
   localparam logic [2:0] OP_DEC = 3'd4;

   logic [CHARGE_WIDTH-1:0] slot_q [DELAY_DEPTH][NUM_INP];
   logic [CHARGE_WIDTH-1:0] slot_d [DELAY_DEPTH][NUM_INP];
   logic [DWS-1:0]          head_q, head_d;
   logic [RUN_WIDTH-1:0]    run_q, run_d;
   logic                    clr_q, clr_d;

   logic [2:0]              w_op;
   logic [RUN_WIDTH-1:0]    w_count;
   logic [CHARGE_WIDTH-1:0] w_value;
   logic [IWS-1:0]          w_idx;
   logic [DWS-1:0]          w_delay;
   logic                    w_idx_ok;
   logic                    w_acc;
   logic                    w_step;
   logic                    w_spk;
   logic [DWS-1:0]          w_target;
   logic [CHARGE_WIDTH:0]   w_sum;
   logic                    w_sat;
   logic                    unused_src;

   assign w_op       = src[SRC_WIDTH-1 -: 3];
   assign w_count    = src[SRC_WIDTH-4 -: RUN_WIDTH];
   assign w_value    = src[VAL_MSB -: CHARGE_WIDTH];
   assign unused_src = ^src;

   generate
      if (IW > 0) begin : g_idx
         assign w_idx = src[SRC_WIDTH-4 -: IWS];
      end else begin : g_idx_none
         assign w_idx = '0;
      end
      if (DW > 0) begin : g_dly
         assign w_delay = src[SRC_WIDTH-4-IW -: DWS];
      end else begin : g_dly_none
         assign w_delay = '0;
      end
      // Only non-power-of-two channel counts can encode an out-of-range index.
      if (NUM_INP == (1 << IW)) begin : g_idx_full
         assign w_idx_ok = 1'b1;
      end else begin : g_idx_chk
         assign w_idx_ok = (w_idx < IWS'(NUM_INP));
      end
   endgenerate

   assign src_ready = (run_q <= RUN_WIDTH'(1));
   assign net_valid = (run_q != '0);
   assign w_acc     = src_valid && src_ready;
   assign w_step    = net_valid && net_ready;
   assign w_spk     = w_acc && (w_op == OP_SPK) && w_idx_ok;
   assign out_ready = w_acc && (w_op == OP_DEC);
   assign net_clr   = clr_q;

   always_comb begin
      run_d    = run_q;
      slot_d   = slot_q;
      head_d   = head_q;
      clr_d    = w_acc && (w_op == OP_CLR);
      w_target = '0;
      w_sum    = '0;
      w_sat    = 1'b0;

      if (w_acc && (w_op == OP_RUN)) begin
         run_d = (w_count == '0) ? RUN_WIDTH'(1) : w_count;
      end else if (w_step) begin
         run_d = run_q - RUN_WIDTH'(1);
      end

      if (w_step) begin
         for (int i = 0; i < NUM_INP; i++) slot_d[head_q][i] = '0;
         head_d = (DELAY_DEPTH == 1) ? '0 : head_q + 1'b1;
      end

      // Spike lands relative to the post-step head, on top of any same-cycle clear.
      if (w_spk) begin
         w_target = head_d + w_delay;
         w_sum = {slot_d[w_target][w_idx][CHARGE_WIDTH-1], slot_d[w_target][w_idx]}
               + {w_value[CHARGE_WIDTH-1], w_value};
         if (w_sum[CHARGE_WIDTH] != w_sum[CHARGE_WIDTH-1]) begin
            w_sat = 1'b1;
            slot_d[w_target][w_idx] = w_sum[CHARGE_WIDTH]
               ? {1'b1, {(CHARGE_WIDTH-1){1'b0}}}
               : {1'b0, {(CHARGE_WIDTH-1){1'b1}}};
         end else begin
            slot_d[w_target][w_idx] = w_sum[CHARGE_WIDTH-1:0];
         end
      end

      if (clr_d) begin
         for (int d = 0; d < DELAY_DEPTH; d++)
            for (int i = 0; i < NUM_INP; i++) slot_d[d][i] = '0;
         head_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < DELAY_DEPTH; d++)
            for (int i = 0; i < NUM_INP; i++) slot_q[d][i] <= '0;
         head_q <= '0;
         run_q  <= '0;
         clr_q  <= 1'b0;
      end else begin
         slot_q <= slot_d;
         head_q <= head_d;
         run_q  <= run_d;
         clr_q  <= clr_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_INP; gi++) begin : g_out
         assign net_inp[gi*CHARGE_WIDTH +: CHARGE_WIDTH] = slot_q[head_q][gi];
      end
   endgenerate

`ifdef DISPATCH_SAT_CNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (clr_d) sat_cnt_d = '0;
      else if (w_sat && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) sat_cnt_q <= '0;
      else     sat_cnt_q <= sat_cnt_d;
   end

   assign sat_count = sat_cnt_q;
`else
   logic unused_sat;
   assign unused_sat = w_sat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dispatch_source_sched.sv
// Randomized + directed bench for dispatch_source_sched against a behavioural slot-ring model.
`default_nettype none

module tb_dispatch_source_sched;

   localparam int NI = 6;   // non-power-of-two so out-of-range SPK indices are encodable
   localparam int CW = 8;
   localparam int DD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          src_valid = 1'b0;
   logic          src_ready;
   logic [31:0]   src = '0;
   logic          out_ready;
   logic          net_ready = 1'b0;
   logic          net_valid;
   logic          net_clr;
   logic [NI*CW-1:0] net_inp;
`ifdef DISPATCH_SAT_CNT_EN
   logic [15:0]   sat_count;
`endif

   dispatch_source_sched #(
      .NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(16), .DELAY_DEPTH(DD), .SRC_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready), .src(src),
      .out_ready(out_ready), .net_ready(net_ready), .net_valid(net_valid),
      .net_clr(net_clr), .net_inp(net_inp)
`ifdef DISPATCH_SAT_CNT_EN
      , .sat_count(sat_count)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // reference model
   int  m_slot [DD][NI];
   int  m_head;
   int  m_run;
   bit  m_clr;
   int  m_sat;
   bit  m_ok = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_run(input int n);
      logic [15:0] c = 16'(n);
      return {3'd1, c, 13'd0};
   endfunction

   function automatic logic [31:0] mk_spk(input int idx, input int dly, input int val);
      logic [2:0] i = 3'(idx);
      logic [1:0] d = 2'(dly);
      logic [7:0] v = 8'(val);
      return {3'd2, i, d, v, 16'd0};
   endfunction

   function automatic logic [31:0] mk_op(input int op);
      logic [2:0] o = 3'(op);
      return {o, 29'd0};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < DD; d++)
         for (int i = 0; i < NI; i++) m_slot[d][i] = 0;
      m_head = 0; m_run = 0; m_clr = 0; m_sat = 0;
   endtask

   // One clock: drive at negedge, check outputs, advance model, wait posedge.
   task automatic cyc(input bit v, input logic [31:0] w, input bit nr, input bit r);
      logic [NI*CW-1:0] exp_inp;
      bit acc, step;
      int op, idx, dly, val, t, s;
      @(negedge clk);
      src_valid = v; src = w; net_ready = nr; rst = r;
      #1;
      acc  = v && (m_run <= 1);
      op   = int'(w[31:29]);
      step = (m_run > 0) && nr;
      if (m_ok) begin
         for (int i = 0; i < NI; i++) exp_inp[i*CW +: CW] = 8'(m_slot[m_head][i]);
         chk("src_ready", 64'(src_ready), 64'(m_run <= 1));
         chk("net_valid", 64'(net_valid), 64'(m_run > 0));
         chk("out_ready", 64'(out_ready), 64'(acc && op == 4));
         chk("net_clr",   64'(net_clr),   64'(m_clr));
         chk("net_inp",   64'(net_inp),   64'(exp_inp));
`ifdef DISPATCH_SAT_CNT_EN
         chk("sat_count", 64'(sat_count), 64'(m_sat));
`endif
      end
      if (r) begin
         model_reset();
         m_ok = 1;
      end else if (m_ok) begin
         if (acc && op == 1) m_run = (w[28:13] == 0) ? 1 : int'(w[28:13]);
         else if (step) m_run = m_run - 1;
         if (step) begin
            for (int i = 0; i < NI; i++) m_slot[m_head][i] = 0;
            m_head = (m_head + 1) % DD;
         end
         if (acc && op == 2 && int'(w[28:26]) < NI) begin
            idx = int'(w[28:26]);
            dly = int'(w[25:24]);
            val = int'($signed(w[23:16]));
            t = (m_head + dly) % DD;
            s = m_slot[t][idx] + val;
            if (s > 127 || s < -128) begin
               s = (s > 127) ? 127 : -128;
               if (m_sat < 65535) m_sat++;
            end
            m_slot[t][idx] = s;
         end
         m_clr = acc && op == 3;
         if (m_clr) begin
            for (int d = 0; d < DD; d++)
               for (int i = 0; i < NI; i++) m_slot[d][i] = 0;
            m_head = 0;
            m_sat = 0;
         end
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, '0, 1, 0);
   endtask

   initial begin
      int op_sel, vsel;
      logic [31:0] w;

      cyc(0, '0, 0, 1);
      idle(1);

      // RUN 3 with net_ready high
      cyc(1, mk_run(3), 1, 0);
      idle(4);

      // accumulation on channel 2
      cyc(1, mk_spk(2, 0, 5), 1, 0);
      cyc(1, mk_spk(2, 0, 7), 1, 0);
      #2 chk("ch2_accum", 64'(net_inp[2*CW +: CW]), 64'(8'd12));
      cyc(1, mk_run(1), 1, 0);
      idle(3);

      // delayed negative spike, full wrap
      cyc(1, mk_spk(1, 3, -4), 1, 0);
      cyc(1, mk_run(4), 1, 0);
      idle(6);

      // saturation both directions
      cyc(1, mk_spk(0, 0, 100), 1, 0);
      cyc(1, mk_spk(0, 0, 100), 1, 0);
      #2 chk("ch0_sat_pos", 64'(net_inp[0 +: CW]), 64'(8'h7F));
      cyc(1, mk_spk(3, 0, -128), 1, 0);
      cyc(1, mk_spk(3, 0, -128), 1, 0);
      #2 chk("ch3_sat_neg", 64'(net_inp[3*CW +: CW]), 64'(8'h80));
      cyc(1, mk_run(1), 1, 0);
      idle(2);

      // pending spikes in every slot, then CLR
      for (int d = 0; d < DD; d++) cyc(1, mk_spk(d, d, 9 + d), 1, 0);
      cyc(1, mk_op(3), 1, 0);
      #2 chk("clr_pulse", 64'(net_clr), 64'(1));
      chk("clr_inp_zero", 64'(net_inp), 64'(0));
      cyc(1, mk_run(4), 1, 0);
      idle(6);

      // stalled run, out-of-range SPK, DEC, then mid-run reset
      cyc(1, mk_run(2), 0, 0);
      cyc(1, mk_spk(7, 0, 33), 0, 0);
      cyc(1, mk_op(4), 0, 0);
      cyc(1, mk_spk(6, 1, 21), 1, 0);
      cyc(1, mk_spk(7, 0, 33), 1, 0);
      cyc(1, mk_op(4), 1, 0);
      cyc(1, mk_run(5), 1, 0);
      cyc(0, '0, 1, 1);
      #2 chk("rst_src_ready", 64'(src_ready), 64'(1));
      chk("rst_net_valid", 64'(net_valid), 64'(0));
      idle(2);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         op_sel = $urandom_range(0, 99);
         w = $urandom;
         if (op_sel < 20)      w = mk_run($urandom_range(0, 4)) | 32'($urandom_range(0, 8191));
         else if (op_sel < 65) begin
            vsel = $urandom_range(0, 3);
            w = mk_spk($urandom_range(0, 7), $urandom_range(0, 3),
                       (vsel == 0) ? $urandom_range(100, 127) :
                       (vsel == 1) ? -$urandom_range(100, 128) : $urandom_range(0, 255))
                | 32'($urandom_range(0, 65535));
         end
         else if (op_sel < 70) w = mk_op(3);
         else if (op_sel < 80) w = mk_op(4) | 32'($urandom);
         else if (op_sel < 90) w = {3'd0, w[28:0]};
         else                  w = {3'($urandom_range(5, 7)), w[28:0]};
         if ($urandom_range(0, 99) == 0) cyc(0, w, 1, 1);
         else cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
